// File: rtl/mult_job_dispatcher.sv
// Job dispatcher in front of the iterative 32x32 multiplier: queues operand pairs,
// runs the multiplier handshake one job at a time and holds each product for downstream.
module mult_job_dispatcher #(
  parameter int DEPTH        = 4,
  parameter int VALID_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       iPush,
  input  logic [31:0]                iData_A,
  input  logic [31:0]                iData_B,
  output logic                       oFull,
  output logic [$clog2(DEPTH):0]     oCount,
  output logic [31:0]                oMul_A,
  output logic [31:0]                oMul_B,
  output logic                       oMul_Valid,
  output logic                       oMul_Ack,
  input  logic                       iMul_Idle,
  input  logic                       iMul_Done,
  input  logic [63:0]                iMul_Result,
  output logic [63:0]                oResult,
  output logic                       oResult_Valid,
  input  logic                       iResult_Ready,
  output logic                       oOverflow,
  output logic                       oTimeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int VW = (VALID_CYCLES > 1) ? $clog2(VALID_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic            mul_valid_q, mul_valid_d, mul_ack_q, mul_ack_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [63:0]     result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            overflow_q, overflow_d, timeout_q, timeout_d;
  logic [63:0]     mem [DEPTH];

  logic full, push_ok, pop;

  assign full    = (count_q == CW'(DEPTH));
  assign push_ok = iPush && !full;
  // A job only starts when the multiplier is free and the previous product has left.
  assign pop     = (state_q == IDLE) && (count_q != '0) && iMul_Idle && !iMul_Done
                   && !result_valid_q;

  // NOTE: the operand array has no reset; pointers and count alone say which entries are live.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr_q] <= {iData_A, iData_B};
  end

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    mul_valid_d    = mul_valid_q;
    mul_ack_d      = mul_ack_q;
    vcnt_d         = vcnt_q;
    timer_d        = timer_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;
    timeout_d      = timeout_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (iPush && full) overflow_d = 1'b1;
    if (result_valid_q && iResult_Ready) result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          mul_a_d     = mem[rd_ptr_q][63:32];
          mul_b_d     = mem[rd_ptr_q][31:0];
          mul_valid_d = 1'b1;
          vcnt_d      = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (vcnt_q == VW'(VALID_CYCLES - 1)) begin
          mul_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = WAIT_DONE;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
        end
      end
      WAIT_DONE: begin
        if (iMul_Done) begin
          result_d       = iMul_Result;
          result_valid_d = 1'b1;
          mul_ack_d      = 1'b1;
          state_d        = ACK;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ACK: begin
        if (!iMul_Done) begin
          mul_ack_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every register sees pre-edge values of the others.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_valid_q    <= 1'b0;
      mul_ack_q      <= 1'b0;
      vcnt_q         <= '0;
      timer_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_valid_q    <= mul_valid_d;
      mul_ack_q      <= mul_ack_d;
      vcnt_q         <= vcnt_d;
      timer_q        <= timer_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      timeout_q      <= timeout_d;
    end
  end

  assign oFull         = full;
  assign oCount        = count_q;
  assign oMul_A        = mul_a_q;
  assign oMul_B        = mul_b_q;
  assign oMul_Valid    = mul_valid_q;
  assign oMul_Ack      = mul_ack_q;
  assign oResult       = result_q;
  assign oResult_Valid = result_valid_q;
  assign oOverflow     = overflow_q;
  assign oTimeout      = timeout_q;

endmodule

// File: tb/tb_mult_job_dispatcher.sv
// Directed bench for mult_job_dispatcher with a behavioural iterative multiplier
// and a product scoreboard filled at push time.
module tb_mult_job_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int MUL_LAT = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iPush = 1'b0;
  logic [31:0] iData_A = '0, iData_B = '0;
  logic        oFull;
  logic [2:0]  oCount;
  logic [31:0] oMul_A, oMul_B;
  logic        oMul_Valid, oMul_Ack;
  logic        iMul_Idle, iMul_Done;
  logic [63:0] iMul_Result;
  logic [63:0] oResult;
  logic        oResult_Valid;
  logic        iResult_Ready = 1'b0;
  logic        oOverflow, oTimeout;

  mult_job_dispatcher #(.DEPTH(DEPTH), .VALID_CYCLES(2), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .iPush(iPush), .iData_A(iData_A), .iData_B(iData_B),
    .oFull(oFull), .oCount(oCount), .oMul_A(oMul_A), .oMul_B(oMul_B),
    .oMul_Valid(oMul_Valid), .oMul_Ack(oMul_Ack), .iMul_Idle(iMul_Idle),
    .iMul_Done(iMul_Done), .iMul_Result(iMul_Result), .oResult(oResult),
    .oResult_Valid(oResult_Valid), .iResult_Ready(iResult_Ready),
    .oOverflow(oOverflow), .oTimeout(oTimeout)
  );

  always #5 Clock = ~Clock;

  // Behavioural multiplier: starts on valid while idle, raises done MUL_LAT edges later,
  // holds done until acknowledged. With hang set it ignores jobs entirely.
  logic        hang = 1'b0;
  logic [63:0] mdl_prod;
  int          mdl_cnt;
  always @(posedge Clock) begin
    if (Reset) begin
      iMul_Idle   <= 1'b1;
      iMul_Done   <= 1'b0;
      iMul_Result <= '0;
      mdl_cnt     <= 0;
      mdl_prod    <= '0;
    end else if (iMul_Done) begin
      if (oMul_Ack) begin
        iMul_Done <= 1'b0;
        iMul_Idle <= 1'b1;
      end
    end else if (!iMul_Idle) begin
      if (mdl_cnt == 1) begin
        iMul_Done   <= 1'b1;
        iMul_Result <= mdl_prod;
      end
      mdl_cnt <= mdl_cnt - 1;
    end else if (oMul_Valid && !hang) begin
      iMul_Idle <= 1'b0;
      mdl_cnt   <= MUL_LAT;
      mdl_prod  <= {32'b0, oMul_A} * {32'b0, oMul_B};
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit accepted,
                           input bit produces, input int exp_count, input bit exp_full);
    iPush = 1'b1; iData_A = a; iData_B = b;
    if (accepted && produces) sb.push_back({32'b0, a} * {32'b0, b});
    @(negedge Clock);
    iPush = 1'b0;
    check("count", 64'(oCount), 64'(exp_count));
    check("full", 64'(oFull), 64'(exp_full));
  endtask

  task automatic expect_issue(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    int n = 0;
    while (!oMul_Valid && t < 100) begin @(negedge Clock); t++; end
    check("issue_seen", 64'(oMul_Valid), 1);
    check("mul_a", 64'(oMul_A), 64'(a));
    check("mul_b", 64'(oMul_B), 64'(b));
    while (oMul_Valid && n < 10) begin n++; @(negedge Clock); end
    check("valid_cycles", 64'(n), 2);
  endtask

  task automatic wait_result();
    int t = 0;
    while (!oResult_Valid && t < 200) begin @(negedge Clock); t++; end
    check("result_seen", 64'(oResult_Valid), 1);
  endtask

  task automatic expect_result();
    logic [63:0] exp;
    wait_result();
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check("result", oResult, exp);
    if (!iResult_Ready) begin
      iResult_Ready = 1'b1;
      @(negedge Clock);
      iResult_Ready = 1'b0;
    end else begin
      @(negedge Clock);
    end
    check("result_drop", 64'(oResult_Valid), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check("rst_count", 64'(oCount), 0);
    check("rst_full", 64'(oFull), 0);
    check("rst_valid", 64'(oMul_Valid), 0);
    check("rst_ack", 64'(oMul_Ack), 0);
    check("rst_result", oResult, 0);
    check("rst_rvalid", 64'(oResult_Valid), 0);
    check("rst_ovf", 64'(oOverflow), 0);
    check("rst_tmo", 64'(oTimeout), 0);

    // Single job, downstream always ready
    iResult_Ready = 1'b1;
    push_pair(32'd3, 32'd7, 1'b1, 1'b1, 1, 1'b0);
    expect_issue(32'd3, 32'd7);
    expect_result();
    check("ack_high", 64'(oMul_Ack), 1);
    check("done_low", 64'(iMul_Done), 0);
    @(negedge Clock);
    check("ack_low", 64'(oMul_Ack), 0);
    check("count_zero", 64'(oCount), 0);
    check("held_21", oResult, 64'd21);
    iResult_Ready = 1'b0;

    // Held product blocks issue; fill the FIFO and overflow it meanwhile
    push_pair(32'd6, 32'd9, 1'b1, 1'b1, 1, 1'b0);
    expect_issue(32'd6, 32'd9);
    wait_result();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("hold_valid", 64'(oResult_Valid), 1);
      check("hold_54", oResult, 64'd54);
    end
    push_pair(32'd1, 32'd1, 1'b1, 1'b1, 1, 1'b0);
    push_pair(32'd2, 32'd2, 1'b1, 1'b1, 2, 1'b0);
    push_pair(32'd3, 32'd3, 1'b1, 1'b1, 3, 1'b0);
    push_pair(32'd4, 32'd4, 1'b1, 1'b1, 4, 1'b1);
    check("ovf_before", 64'(oOverflow), 0);
    push_pair(32'd5, 32'd5, 1'b0, 1'b1, 4, 1'b1);
    check("ovf_after", 64'(oOverflow), 1);
    check("blocked_valid", 64'(oMul_Valid), 0);
    for (int i = 0; i < 5; i++) expect_result();
    check("drain_count", 64'(oCount), 0);

    // Hung job: timeout after 16 WAIT_DONE cycles, then the queued job runs
    hang = 1'b1;
    push_pair(32'd11, 32'd13, 1'b1, 1'b0, 1, 1'b0);
    push_pair(32'd7, 32'd8, 1'b1, 1'b1, 1, 1'b0);
    expect_issue(32'd11, 32'd13);
    hang = 1'b0;
    repeat (15) @(negedge Clock);
    check("tmo_not_yet", 64'(oTimeout), 0);
    @(negedge Clock);
    check("tmo_set", 64'(oTimeout), 1);
    expect_issue(32'd7, 32'd8);
    expect_result();

    // Reset during WAIT_DONE with two entries queued
    hang = 1'b1;
    push_pair(32'd21, 32'd22, 1'b1, 1'b0, 1, 1'b0);
    expect_issue(32'd21, 32'd22);
    push_pair(32'd23, 32'd24, 1'b1, 1'b0, 1, 1'b0);
    push_pair(32'd25, 32'd26, 1'b1, 1'b0, 2, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_count", 64'(oCount), 0);
    check("mid_full", 64'(oFull), 0);
    check("mid_a", 64'(oMul_A), 0);
    check("mid_b", 64'(oMul_B), 0);
    check("mid_valid", 64'(oMul_Valid), 0);
    check("mid_ack", 64'(oMul_Ack), 0);
    check("mid_result", oResult, 0);
    check("mid_rvalid", 64'(oResult_Valid), 0);
    check("mid_ovf", 64'(oOverflow), 0);
    check("mid_tmo", 64'(oTimeout), 0);
    Reset = 1'b0;
    hang  = 1'b0;
    repeat (4) @(negedge Clock);
    check("post_rst_valid", 64'(oMul_Valid), 0);

    // All-ones operands
    iResult_Ready = 1'b1;
    push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 1'b0);
    expect_issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result();
    check("max_exact", oResult, 64'hFFFF_FFFE_0000_0001);
    check("sb_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_job_dispatcher.md
Name: mult_job_dispatcher

Overview:
Upstream feeder for the iterative 32x32 multiplier. Buffers operand pairs in a small FIFO and drives the multiplier's valid/done/acknowledge handshake one job at a time. Captures each 64-bit product into a single-entry output register with a valid/ready interface. Flags lost operands and hung multiplier jobs through sticky error bits.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
VALID_CYCLES, 2, cycles oMul_Valid stays high per issue (>=1)
TIMEOUT, 1024, max cycles in WAIT_DONE before abort

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high; one clock, sync reset, active-high
iPush  in  1  write operand pair into FIFO
iData_A  in  32  operand A
iData_B  in  32  operand B
oFull  out  1  FIFO holds DEPTH entries
oCount  out  $clog2(DEPTH)+1  FIFO occupancy
oMul_A  out  32  operand A to multiplier iData_A
oMul_B  out  32  operand B to multiplier iData_B
oMul_Valid  out  1  to multiplier iValid_Data
oMul_Ack  out  1  to multiplier iAcknoledged
iMul_Idle  in  1  from multiplier oIdle
iMul_Done  in  1  from multiplier oDone
iMul_Result  in  64  from multiplier oResult
oResult  out  64  captured product
oResult_Valid  out  1  oResult holds an unconsumed product
iResult_Ready  in  1  downstream takes oResult
oOverflow  out  1  sticky: push while full
oTimeout  out  1  sticky: job aborted on TIMEOUT

Behaviour:
- Reset (sync, Reset=1 at rising edge) clears all state. FIFO empties, oCount=0, oFull=0. oMul_A/B=0, oMul_Valid=0, oMul_Ack=0, oResult=0, oResult_Valid=0, oOverflow=0, oTimeout=0, FSM=IDLE. Reset mid-job abandons the job without acknowledging it. The multiplier shares Reset.
- FIFO: push accepted when iPush=1 and oFull=0. Push while full is dropped and sets oOverflow. Push and pop in the same cycle are both performed, so count is unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE, ACK.
- IDLE: when count>0, iMul_Idle=1, iMul_Done=0 and oResult_Valid=0, pop the head into oMul_A/oMul_B and go to ISSUE. oMul_A/B stay stable until the next pop.
- ISSUE: oMul_Valid=1 for exactly VALID_CYCLES consecutive cycles, starting the cycle after the pop, then go to WAIT_DONE. oMul_Valid is registered.
- WAIT_DONE: oMul_Valid=0 and a cycle counter runs.
  - On iMul_Done=1: capture iMul_Result into oResult, set oResult_Valid the next cycle, go to ACK.
  - If the counter reaches TIMEOUT first: set oTimeout, drop the job, go to IDLE. No result is produced.
- ACK: oMul_Ack=1 while iMul_Done=1. When iMul_Done=0 is sampled, clear oMul_Ack and go to IDLE.
- Output register: oResult_Valid clears on the cycle after iResult_Ready=1 while valid. oResult holds its value until the next capture. No new job issues while oResult_Valid=1, so a product is never overwritten.
- Minimum job latency is pop to oResult_Valid = VALID_CYCLES + multiplier latency + 1.
- No arithmetic is done here. Operands pass through unchanged, and the product is a raw 64-bit copy.

Test Plan:
- Reset, push A=3,B=7, iResult_Ready=1 -> oMul_Valid high 2 cycles with oMul_A=3,oMul_B=7; oResult=21 with oResult_Valid pulse; oMul_Ack rises after iMul_Done and falls after it drops; oCount returns to 0.
- Push 5 pairs (1x1,2x2,3x3,4x4,5x5) back-to-back with DEPTH=4 while the multiplier is busy -> oFull=1 after 4th push, 5th dropped, oOverflow=1; results 1,4,9,16 emitted in order.
- Hold iResult_Ready=0 after first product 6x9 -> oResult=54 held, oResult_Valid=1, next queued pair not issued (oMul_Valid stays 0) until Ready=1.
- Stub multiplier never asserts iMul_Done, TIMEOUT=16 -> 16 cycles after WAIT_DONE entry oTimeout=1, FSM back to IDLE, next queued job issued.
- Assert Reset during WAIT_DONE with 2 entries queued -> next cycle all outputs at reset values, oCount=0, sticky flags cleared.
- Push 0xFFFFFFFF x 0xFFFFFFFF -> oResult=0xFFFFFFFE00000001 bit-exact, and it matches the behavioural multiplier.
